// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC/instruction-memory fetch sequencer for the Hack-style CPU
module fetch_sequencer #(
    parameter int WIDTH   = 16,
    parameter int MEM_LAT = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             halt_req,
    input  logic             exec_done,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_addr,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] mem_data,
    output logic [WIDTH-1:0] pc_in,
    output logic             pc_load,
    output logic             pc_inc,
    output logic             pc_reset,
    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_rd,
    output logic [WIDTH-1:0] instr,
    output logic             instr_valid,
    output logic             busy,
    output logic             halted,
    output logic [WIDTH-1:0] icount
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_EXEC  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    // Memory latency is at most 4, so a 3-bit down-counter is enough.
    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

    state_t     state, state_nx;
    logic [2:0] wait_cnt, wait_cnt_nx;
    logic       halt_pend, halt_pend_nx;
    logic       load_instr;
    logic       retire;

    // Next-state decode plus Moore outputs; PC load/inc react to exec_done in the same cycle.
    always_comb begin
        state_nx     = state;
        wait_cnt_nx  = wait_cnt;
        halt_pend_nx = halt_pend;
        load_instr   = 1'b0;
        retire       = 1'b0;
        pc_in        = '0;
        pc_load      = 1'b0;
        pc_inc       = 1'b0;
        pc_reset     = 1'b0;
        mem_addr     = '0;
        mem_rd       = 1'b0;
        instr_valid  = 1'b0;
        busy         = 1'b0;
        halted       = 1'b0;
        case (state)
            S_IDLE: begin
                pc_reset = 1'b1;
                if (start) begin
                    state_nx = S_FETCH;
                end
            end
            S_FETCH: begin
                busy        = 1'b1;
                mem_rd      = 1'b1;
                mem_addr    = pc;
                wait_cnt_nx = LAT_INIT;
                state_nx    = S_WAIT;
                if (halt_req) begin
                    halt_pend_nx = 1'b1;
                end
            end
            S_WAIT: begin
                busy        = 1'b1;
                mem_addr    = pc;
                wait_cnt_nx = wait_cnt - 3'd1;
                if (halt_req) begin
                    halt_pend_nx = 1'b1;
                end
                if (wait_cnt == 3'd1) begin
                    load_instr = 1'b1;
                    state_nx   = S_EXEC;
                end
            end
            S_EXEC: begin
                busy        = 1'b1;
                instr_valid = 1'b1;
                mem_addr    = pc;
                if (exec_done) begin
                    retire = 1'b1;
                    if (jump) begin
                        pc_load = 1'b1;
                        pc_in   = jump_addr;
                    end else begin
                        pc_inc = 1'b1;
                    end
                    // A halt request is only honoured once the instruction retires.
                    state_nx     = (halt_req || halt_pend) ? S_HALT : S_FETCH;
                    halt_pend_nx = 1'b0;
                end else if (halt_req) begin
                    halt_pend_nx = 1'b1;
                end
            end
            S_HALT: begin
                halted   = 1'b1;
                mem_addr = pc;
                if (start) begin
                    state_nx = S_FETCH;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // State, wait counter, latched instruction and retirement counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            wait_cnt  <= 3'd0;
            halt_pend <= 1'b0;
            instr     <= '0;
            icount    <= '0;
        end else begin
            state     <= state_nx;
            wait_cnt  <= wait_cnt_nx;
            halt_pend <= halt_pend_nx;
            if (load_instr) begin
                instr <= mem_data;
            end
            if (retire) begin
                icount <= icount + WIDTH'(1);
            end
        end
    end

endmodule
